// File: rtl/instr_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and immediate generator.
// Holds opcodes, the request format enumeration and the canonical NOP word.
package instr_encoder_pkg;

    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_I_ALU  = 3'd0,
        FMT_LOAD   = 3'd1,
        FMT_STORE  = 3'd2,
        FMT_BRANCH = 3'd3,
        FMT_JAL    = 3'd4,
        FMT_JALR   = 3'd5
    } fmt_t;

    // True when imm[63:msb] is a pure sign extension (all zeros or all ones).
    function automatic logic fits_signed(input logic [63:0] imm, input int unsigned msb);
        logic signed [63:0] hi;
        hi = $signed(imm) >>> msb;
        return (hi == '0) || (hi == '1);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: builds the 32-bit word for one request and
// flags illegal formats or immediates that do not fit the target field.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [63:0] imm,
    output logic [31:0] word,
    output logic        err
);

    logic [31:0] raw;
    logic        legal;

    always_comb begin
        raw   = NOP_INSTR;
        legal = 1'b0;
        case (fmt)
            FMT_I_ALU: begin
                raw   = {imm[11:0], rs1, funct3, rd, OP_I_ALU};
                legal = fits_signed(imm, 11);
            end
            FMT_LOAD: begin
                raw   = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                legal = fits_signed(imm, 11);
            end
            FMT_STORE: begin
                raw   = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                legal = fits_signed(imm, 11);
            end
            FMT_BRANCH: begin
                raw   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                legal = fits_signed(imm, 12) && !imm[0];
            end
            FMT_JAL: begin
                raw   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
                legal = fits_signed(imm, 20) && !imm[0];
            end
            FMT_JALR: begin
                // Offset is treated as unsigned here, so only 0..4095 is accepted.
                raw   = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
                legal = (imm[63:12] == '0);
            end
            default: begin
                raw   = NOP_INSTR;
                legal = 1'b0;
            end
        endcase
        word = legal ? raw : NOP_INSTR;
        err  = !legal;
    end

endmodule

// File: rtl/instr_encoder.sv
// Request/response wrapper around instr_pack: three-phase capture, encode,
// present handshake with a running address and a saturating error counter.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_addr,
    output logic        out_err,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [2:0]  cap_fmt;
    logic [4:0]  cap_rd, cap_rs1, cap_rs2;
    logic [2:0]  cap_funct3;
    logic [63:0] cap_imm;
    logic [31:0] pack_word;
    logic        pack_err;

    assign in_ready  = (state == IDLE) && !flush && !reset;
    assign out_valid = (state == OUT);

    instr_pack u_pack (
        .fmt    (cap_fmt),
        .rd     (cap_rd),
        .rs1    (cap_rs1),
        .rs2    (cap_rs2),
        .funct3 (cap_funct3),
        .imm    (cap_imm),
        .word   (pack_word),
        .err    (pack_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ENC;
            ENC:     state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_fmt    <= '0;
            cap_rd     <= '0;
            cap_rs1    <= '0;
            cap_rs2    <= '0;
            cap_funct3 <= '0;
            cap_imm    <= '0;
        end else if (in_valid && in_ready) begin
            cap_fmt    <= in_fmt;
            cap_rd     <= in_rd;
            cap_rs1    <= in_rs1;
            cap_rs2    <= in_rs2;
            cap_funct3 <= in_funct3;
            cap_imm    <= in_imm;
        end
    end

    // Flush clears the presented word and address but keeps the error tally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_instr <= NOP_INSTR;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
            err_count <= '0;
        end else if (flush) begin
            out_instr <= NOP_INSTR;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
        end else if (state == ENC) begin
            out_instr <= pack_word;
            out_err   <= pack_err;
        end else if (state == OUT && out_ready) begin
            out_addr <= out_addr + 64'd4;
            if (out_err && err_count != '1) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0, first instruction address after reset or flush.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous restart: address to BASE_ADDR, state to IDLE.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-007 SHALL have port in_fmt  input  3  0 I-ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 JALR, 6-7 illegal.
REQ-008 SHALL have ports in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-009 SHALL have port in_funct3  input  3  funct3 field.
REQ-010 SHALL have port in_imm  input  64  byte-offset immediate, two's complement.
REQ-011 SHALL have port out_valid  output  1  encoded word present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts when out_valid & out_ready.
REQ-013 SHALL have ports out_instr  output  32  encoded word; out_addr  output  64  its address; out_err  output  1  request rejected.
REQ-014 SHALL have port err_count  output  16  rejected requests, saturating at 16'hFFFF.

Function
REQ-015 SHALL implement FSM IDLE -> ENC -> OUT -> IDLE; in_ready = (state==IDLE) & ~flush.
REQ-016 IDLE: on accept, register all in_* fields and go to ENC; otherwise stay.
REQ-017 ENC: one cycle; compute range check and word, register into out_instr/out_err, go to OUT.
REQ-018 OUT: out_valid=1; out_instr, out_addr and out_err SHALL remain stable until out_ready=1, then return to IDLE, out_addr += 4 (wraps modulo 2^64), err_count += out_err (saturating).
REQ-019 Latency: out_valid SHALL rise exactly 2 cycles after the accept edge; maximum throughput is one word per 3 cycles.
REQ-020 Opcodes: I-ALU 7'b0010011, LOAD 7'b0000011, STORE 7'b0100011, BRANCH 7'b1100011, JAL 7'b1101111, JALR 7'b1100111.
REQ-021 I-ALU/LOAD: {imm[11:0], rs1, funct3, rd, op}; legal iff imm[63:11] is all 0s or all 1s.
REQ-022 JALR: {imm[11:0], rs1, 3'b000, rd, op}, funct3 input ignored; legal iff imm[63:12]==0 (zero-extended 0..4095).
REQ-023 STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}; legal iff imm[63:11] is all 0s or all 1s.
REQ-024 BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}; legal iff imm[63:12] is all 0s or all 1s and imm[0]==0.
REQ-025 JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; legal iff imm[63:20] is all 0s or all 1s and imm[0]==0.
REQ-026 Illegal format or out-of-range immediate: out_err=1, out_instr=32'h00000013 (NOP); the word is still emitted and the address still advances.
REQ-027 Flush SHALL take priority over every other event in every state; an in-flight word is discarded without handshake, err_count is not updated and err_count is retained.

Reset
REQ-028 Reset asserted: state=IDLE, out_valid=0, out_instr=32'h00000013, out_err=0, out_addr=BASE_ADDR, err_count=0, in_ready=0 while reset is high.
REQ-029 Reset mid-operation SHALL discard any captured or pending word; the first word after release is at BASE_ADDR.

Structure
REQ-030 A shared package SHALL hold the opcode constants, the fmt enumeration and the NOP constant; the team's immediate generator SHALL reuse these opcode constants.
REQ-031 Field packing and range check SHALL be one combinational sub-module, instr_pack (fmt, fields, imm -> word, err); instr_encoder holds the FSM, registers and counters.

Verification
REQ-032 fmt0 rd=1 rs1=2 funct3=0 imm=-1 -> out_instr 32'hFFF10093, out_err=0, out_valid 2 cycles after accept.
REQ-033 fmt2 rs1=2 rs2=5 funct3=3'b010 imm=8 -> 32'h00512423; fmt3 rs1=rs2=0 funct3=0 imm=-4 -> 32'hFE000EE3; fmt4 rd=1 imm=2048 -> 32'h001000EF.
REQ-034 fmt3 imm=3, then fmt0 imm=2048, then fmt6 -> three words 32'h00000013 with out_err=1, err_count=3.
REQ-035 BASE_ADDR=64'h1000, three transfers -> out_addr 64'h1000, 64'h1004, 64'h1008; flush, then next transfer -> 64'h1000.
REQ-036 out_ready low for 5 cycles in OUT -> out_valid, out_instr and out_addr stable, in_ready=0; accepts on the 6th cycle.
REQ-037 reset asserted in ENC and separately flush asserted in OUT -> no handshake occurs, values match REQ-028 (err_count retained on flush), next accept is encoded normally.
